// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronizes and glitch-filters A/B/Z, decodes x4 Gray
// transitions into step/direction/index-load strobes for the position counter.
module quad_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enc_a_i,
    input  logic enc_b_i,
    input  logic enc_z_i,
    input  logic enable_i,
    input  logic index_en_i,
    input  logic err_clr_i,
    output logic step_o,
    output logic dir_o,
    output logic load_o,
    output logic err_o,
    output logic err_flag_o,
    output logic ready_o
);

    localparam int FW    = $clog2(FILTER_CYCLES + 1);
    localparam int BLANK = SYNC_STAGES + FILTER_CYCLES + 1;
    localparam int BW    = $clog2(BLANK + 1);

    // True when an AB transition follows the A-leads sequence 00->10->11->01->00.
    function automatic logic is_up(input logic [1:0] from, input logic [1:0] to);
        logic up;
        up = 1'b0;
        case (from)
            2'b00:   up = (to == 2'b10);
            2'b10:   up = (to == 2'b11);
            2'b11:   up = (to == 2'b01);
            default: up = (to == 2'b00);
        endcase
        return up;
    endfunction

    // Stage p0: per-channel synchronizer chains, index 0 is the pin-facing flop.
    logic [SYNC_STAGES-1:0] sync_a_p0, sync_b_p0, sync_z_p0;
    logic [2:0]             s_p0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_a_p0 <= '0;
            sync_b_p0 <= '0;
            sync_z_p0 <= '0;
        end else begin
            sync_a_p0 <= {sync_a_p0[SYNC_STAGES-2:0], enc_a_i};
            sync_b_p0 <= {sync_b_p0[SYNC_STAGES-2:0], enc_b_i};
            sync_z_p0 <= {sync_z_p0[SYNC_STAGES-2:0], enc_z_i};
        end
    end

    assign s_p0 = {sync_z_p0[SYNC_STAGES-1], sync_b_p0[SYNC_STAGES-1], sync_a_p0[SYNC_STAGES-1]};

    // Stage p1: glitch filters; bit 0 = A, bit 1 = B, bit 2 = Z.
    logic [2:0]    f_p1;
    logic [FW-1:0] fcnt_p1 [3];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_p1 <= '0;
            for (int i = 0; i < 3; i++) fcnt_p1[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s_p0[i] != f_p1[i]) begin
                    if (fcnt_p1[i] == FW'(FILTER_CYCLES - 1)) begin
                        f_p1[i]    <= s_p0[i];
                        fcnt_p1[i] <= '0;
                    end else begin
                        fcnt_p1[i] <= fcnt_p1[i] + FW'(1);
                    end
                end else begin
                    fcnt_p1[i] <= '0;
                end
            end
        end
    end

    // Stage p2: previous filtered state, startup blanking and registered strobes.
    logic [1:0]    ab_p1;
    logic [1:0]    prev_ab_p2;
    logic          prev_z_p2;
    logic [1:0]    diff;
    logic [BW-1:0] blank_cnt;
    logic          blank_done;
    logic          active;
    logic          single;
    logic          dbl;

    assign ab_p1      = {f_p1[0], f_p1[1]};
    assign diff       = ab_p1 ^ prev_ab_p2;
    assign blank_done = (blank_cnt == BW'(BLANK));
    assign active     = blank_done && enable_i;
    assign single     = (diff == 2'b01) || (diff == 2'b10);
    assign dbl        = (diff == 2'b11);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_ab_p2 <= '0;
            prev_z_p2  <= 1'b0;
            blank_cnt  <= '0;
            ready_o    <= 1'b0;
            step_o     <= 1'b0;
            dir_o      <= 1'b1;
            load_o     <= 1'b0;
            err_o      <= 1'b0;
            err_flag_o <= 1'b0;
        end else begin
            prev_ab_p2 <= ab_p1;
            prev_z_p2  <= f_p1[2];
            if (!blank_done) blank_cnt <= blank_cnt + BW'(1);
            ready_o <= blank_done;
            step_o  <= active && single;
            if (active && single) dir_o <= is_up(prev_ab_p2, ab_p1);
            err_o   <= active && dbl;
            load_o  <= active && index_en_i && !prev_z_p2 && f_p1[2];
            // A fresh error outranks a simultaneous clear request.
            if (active && dbl) err_flag_o <= 1'b1;
            else if (err_clr_i) err_flag_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios with literal expectations plus a random
// pin walk, all outputs compared every cycle against a sample-history reference model.
module tb_quad_decoder;

    localparam int SYNC  = 2;
    localparam int FC    = 4;
    localparam int BLANK = SYNC + FC + 1;
    localparam int HL    = SYNC + FC;

    logic clk = 1'b0;
    logic rst_i, enc_a_i, enc_b_i, enc_z_i, enable_i, index_en_i, err_clr_i;
    logic step_o, dir_o, load_o, err_o, err_flag_o, ready_o;

    quad_decoder #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FC)) dut (
        .clk_i(clk), .rst_i(rst_i), .enc_a_i(enc_a_i), .enc_b_i(enc_b_i), .enc_z_i(enc_z_i),
        .enable_i(enable_i), .index_en_i(index_en_i), .err_clr_i(err_clr_i),
        .step_o(step_o), .dir_o(dir_o), .load_o(load_o), .err_o(err_o),
        .err_flag_o(err_flag_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Position of an AB code around the A-leads cycle 00,10,11,01.
    function automatic int gray_pos(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] pos_ab(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // Reference model: pin sample history, filtered level flips once FC consecutive
    // synchronized samples disagree with it; decode by position delta around the cycle.
    logic [2:0] hist [HL];
    logic [2:0] mf1, mf2, fn;
    int         since, d;
    bit         act, started = 0;
    logic       e_step, e_dir, e_load, e_err, e_flag, e_rdy;

    always @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < HL; i++) hist[i] = '0;
            mf1 = '0; mf2 = '0; since = 0;
            e_step = 0; e_dir = 1; e_load = 0; e_err = 0; e_flag = 0; e_rdy = 0;
            started = 1;
        end else if (started) begin
            since++;
            act = (since > BLANK) && enable_i;
            for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {enc_z_i, enc_b_i, enc_a_i};
            for (int c = 0; c < 3; c++) begin
                fn[c] = ~mf1[c];
                for (int j = 0; j < FC; j++)
                    if (hist[SYNC+j][c] == mf1[c]) fn[c] = mf1[c];
            end
            d = (gray_pos(mf1[0], mf1[1]) - gray_pos(mf2[0], mf2[1]) + 4) % 4;
            e_step = act && (d == 1 || d == 3);
            if (e_step) e_dir = (d == 1);
            e_err  = act && (d == 2);
            e_load = act && index_en_i && !mf2[2] && mf1[2];
            if (e_err) e_flag = 1;
            else if (err_clr_i) e_flag = 0;
            e_rdy = (since > BLANK);
            mf2 = mf1;
            mf1 = fn;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("step_o", int'(step_o), int'(e_step));
            check("dir_o", int'(dir_o), int'(e_dir));
            check("load_o", int'(load_o), int'(e_load));
            check("err_o", int'(err_o), int'(e_err));
            check("err_flag_o", int'(err_flag_o), int'(e_flag));
            check("ready_o", int'(ready_o), int'(e_rdy));
        end
    end

    int n_step = 0, n_up = 0, n_load = 0, n_err = 0;

    always @(posedge clk) begin
        #1;
        if (step_o) n_step++;
        if (step_o && dir_o) n_up++;
        if (load_o) n_load++;
        if (err_o) n_err++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_counts();
        n_step = 0; n_up = 0; n_load = 0; n_err = 0;
    endtask

    task automatic hold_ab(input logic [1:0] ab, input int n);
        @(negedge clk);
        enc_a_i = ab[1];
        enc_b_i = ab[0];
        tick(n - 1);
    endtask

    int p;
    logic [1:0] ab;

    initial begin
        rst_i = 1; enc_a_i = 1; enc_b_i = 1; enc_z_i = 1;
        enable_i = 1; index_en_i = 1; err_clr_i = 0;

        // Pins high through reset: blanking hides the filtered rise.
        tick(3);
        rst_i = 0;
        clr_counts();
        tick(7);
        check("ready_before_8", int'(ready_o), 0);
        tick(1);
        check("ready_at_8", int'(ready_o), 1);
        tick(20);
        check("startup_steps", n_step, 0);
        check("startup_loads", n_load, 0);
        check("startup_errs", n_err, 0);

        @(negedge clk);
        rst_i = 1; enc_a_i = 0; enc_b_i = 0; enc_z_i = 0;
        tick(2);
        rst_i = 0;
        tick(15);

        // Up cycle with exact latency on the first edge.
        clr_counts();
        @(negedge clk);
        enc_a_i = 1;
        tick(6);
        check("lat_step_early", int'(step_o), 0);
        tick(1);
        check("lat_step_on", int'(step_o), 1);
        check("lat_dir_up", int'(dir_o), 1);
        tick(1);
        check("lat_step_single", int'(step_o), 0);
        tick(8);
        hold_ab(2'b11, 10); hold_ab(2'b01, 10); hold_ab(2'b00, 10);
        tick(8);
        check("up_steps", n_step, 4);
        check("up_dirs", n_up, 4);

        clr_counts();
        hold_ab(2'b01, 10); hold_ab(2'b11, 10); hold_ab(2'b10, 10); hold_ab(2'b00, 10);
        tick(8);
        check("down_steps", n_step, 4);
        check("down_dirs_up", n_up, 0);

        clr_counts();
        hold_ab(2'b10, 10); hold_ab(2'b00, 10);
        tick(8);
        check("reversal_steps", n_step, 2);
        check("reversal_up", n_up, 1);
        check("reversal_dir", int'(dir_o), 0);

        // Glitches: 3 samples filtered out, 4 samples pass both ways.
        clr_counts();
        @(negedge clk); enc_a_i = 1;
        tick(3); enc_a_i = 0;
        tick(15);
        check("glitch3_steps", n_step, 0);
        @(negedge clk); enc_a_i = 1;
        tick(4); enc_a_i = 0;
        tick(15);
        check("pulse4_steps", n_step, 2);
        check("pulse4_up", n_up, 1);

        // Double transition, clear, and error coincident with clear.
        clr_counts();
        hold_ab(2'b11, 15);
        check("dbl_errs", n_err, 1);
        check("dbl_steps", n_step, 0);
        check("dbl_flag", int'(err_flag_o), 1);
        @(negedge clk); err_clr_i = 1;
        @(negedge clk); err_clr_i = 0;
        @(negedge clk);
        check("flag_cleared", int'(err_flag_o), 0);
        @(negedge clk); enc_a_i = 0; enc_b_i = 0;
        tick(6); err_clr_i = 1;
        tick(1); err_clr_i = 0;
        tick(1);
        check("err_wins_flag", int'(err_flag_o), 1);
        check("err_wins_count", n_err, 2);
        tick(10);

        // Index edge together with an A edge.
        clr_counts();
        @(negedge clk); enc_a_i = 1; enc_z_i = 1;
        tick(7);
        check("coinc_step", int'(step_o), 1);
        check("coinc_load", int'(load_o), 1);
        tick(10);
        hold_ab(2'b00, 10);
        @(negedge clk); enc_z_i = 0;
        tick(10);
        check("index_loads", n_load, 1);
        clr_counts();
        index_en_i = 0;
        @(negedge clk); enc_z_i = 1;
        tick(12);
        enc_z_i = 0;
        tick(12);
        check("index_disabled", n_load, 0);
        index_en_i = 1;

        // Steps while disabled, then re-enable.
        clr_counts();
        enable_i = 0;
        hold_ab(2'b10, 10); hold_ab(2'b11, 10); hold_ab(2'b01, 10);
        enable_i = 1;
        tick(20);
        check("disabled_steps", n_step, 0);
        check("disabled_errs", n_err, 0);

        // Random walk with short holds, occasional double jumps, resets and control toggles.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                p = gray_pos(enc_a_i, enc_b_i);
                case ($urandom_range(15))
                    0:       p = p + 2;
                    1, 2, 3, 4, 5, 6, 7: p = p + 1;
                    default: p = p + 3;
                endcase
                ab = pos_ab(p);
                enc_a_i = ab[1];
                enc_b_i = ab[0];
            end
            if ($urandom_range(15) == 0) enc_z_i = ~enc_z_i;
            enable_i   = ($urandom_range(7) != 0);
            index_en_i = $urandom_range(1) == 1;
            err_clr_i  = ($urandom_range(9) == 0);
            rst_i      = ($urandom_range(999) == 0);
        end
        @(negedge clk);
        rst_i = 0; err_clr_i = 0;
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
